// File: rtl/lif_neuron_unit.sv
// Leaky integrate-and-fire neuron stage fed by the synaptic adder tree.
// Each accepted input is one timestep of summed synaptic weight. For that
// timestep the membrane is leaked, the input is integrated, the result is
// saturated, and the result is compared against the threshold. One result
// (spike + membrane value) is produced per timestep through a single output
// register with valid/ready flow control.
//
// Ports
//   clk, nrst          clock (rising edge), async active-low reset
//   clear              sync clear: zero membrane/refractory, drop pending result
//   in_valid/in_ready  input handshake, in_sum = signed summed synaptic input
//   out_valid/ready    output handshake
//   out_spike          neuron fired this timestep
//   out_vmem           membrane after this timestep's update (pre-reset on fire)
//   refrac             refractory counter nonzero
module lif_neuron_unit #(
  parameter int SUM_W        = 8,
  parameter int MEM_W        = 16,
  parameter int THRESH       = 64,
  parameter int LEAK_SHIFT   = 4,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [SUM_W-1:0] in_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_spike,
  output logic signed [MEM_W-1:0] out_vmem,
  output logic                    refrac
);

  // Two guard bits are enough: |v - leak| stays within MEM_W bits and the
  // input is narrower than the membrane.
  localparam int TW    = MEM_W + 2;
  localparam int CNT_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  localparam logic signed [TW-1:0]    T_MAX = {3'b000, {(MEM_W-1){1'b1}}};
  localparam logic signed [TW-1:0]    T_MIN = {3'b111, {(MEM_W-1){1'b0}}};
  localparam logic signed [MEM_W-1:0] V_MAX = {1'b0, {(MEM_W-1){1'b1}}};
  localparam logic signed [MEM_W-1:0] V_MIN = {1'b1, {(MEM_W-1){1'b0}}};
  localparam logic signed [MEM_W-1:0] TH    = MEM_W'(THRESH);

  typedef enum logic {INTEG, REFRAC} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [MEM_W-1:0] v_q, v_d;
  logic                    ov_d, os_d;
  logic signed [MEM_W-1:0] ovm_d;

  logic signed [MEM_W-1:0] leak_v;
  logic signed [TW-1:0]    v_ext, leak_ext, in_ext, t_raw;
  logic signed [MEM_W-1:0] t_sat;
  logic                    fire, accept;

  // Clear blocks acceptance so the input is not consumed during clear.
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign refrac   = (cnt_q != '0);

  // Leak/integrate datapath
  assign leak_v   = v_q >>> LEAK_SHIFT;
  assign v_ext    = {{2{v_q[MEM_W-1]}}, v_q};
  assign leak_ext = (LEAK_SHIFT == 0) ? '0 : {{2{leak_v[MEM_W-1]}}, leak_v};
  assign in_ext   = {{(TW-SUM_W){in_sum[SUM_W-1]}}, in_sum};
  assign t_raw    = v_ext - leak_ext + in_ext;

  always_comb begin
    t_sat = t_raw[MEM_W-1:0];
    if (t_raw > T_MAX)      t_sat = V_MAX;
    else if (t_raw < T_MIN) t_sat = V_MIN;
  end

  assign fire = (t_sat >= TH);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= INTEG;
      cnt_q     <= '0;
      v_q       <= '0;
      out_valid <= 1'b0;
      out_spike <= 1'b0;
      out_vmem  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      v_q       <= v_d;
      out_valid <= ov_d;
      out_spike <= os_d;
      out_vmem  <= ovm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    ov_d    = out_valid && !out_ready;
    os_d    = out_spike;
    ovm_d   = out_vmem;
    if (clear) begin
      state_d = INTEG;
      cnt_d   = '0;
      v_d     = '0;
      ov_d    = 1'b0;
    end else if (accept) begin
      ov_d = 1'b1;
      unique case (state_q)
        INTEG: begin
          ovm_d = t_sat;
          if (fire) begin
            os_d = 1'b1;
            v_d  = '0;
            if (REFRAC_STEPS > 0) begin
              cnt_d   = CNT_W'(REFRAC_STEPS);
              state_d = REFRAC;
            end
          end else begin
            os_d = 1'b0;
            v_d  = t_sat;
          end
        end
        REFRAC: begin
          // Input is swallowed; membrane pinned at rest.
          os_d  = 1'b0;
          ovm_d = '0;
          v_d   = '0;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = INTEG;
        end
        default: state_d = INTEG;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_unit.sv
// Bench for lif_neuron_unit: a default-parameter instance under directed and
// random traffic, plus a saturation instance (no leak, threshold at max).
module tb_lif_neuron_unit;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic              clear = 0, in_valid = 0, out_ready = 1;
  logic signed [7:0] in_sum = '0;
  logic              in_ready, out_valid, out_spike, refrac;
  logic signed [15:0] out_vmem;

  // saturation instance
  logic              s_in_valid = 0;
  logic signed [7:0] s_in_sum = '0;
  logic              s_in_ready, s_out_valid, s_out_spike, s_refrac;
  logic signed [15:0] s_out_vmem;

  lif_neuron_unit u_dut (
    .clk(clk), .nrst(nrst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_spike(out_spike), .out_vmem(out_vmem), .refrac(refrac));

  lif_neuron_unit #(.THRESH(32767), .LEAK_SHIFT(0), .REFRAC_STEPS(0)) u_sat (
    .clk(clk), .nrst(nrst), .clear(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sum(s_in_sum),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_spike(s_out_spike), .out_vmem(s_out_vmem), .refrac(s_refrac));

  int n_total = 0, n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: one timestep of a LIF neuron in plain integers.
  function automatic void lif_step(input int v, input int cnt, input int sum,
                                   input int th, input int sh, input int rf,
                                   output int nv, output int ncnt,
                                   output int sp, output int vm);
    int t;
    if (cnt > 0) begin
      sp = 0; vm = 0; nv = 0; ncnt = cnt - 1;
    end else begin
      t = v - ((sh == 0) ? 0 : (v >>> sh)) + sum;
      if (t > 32767)  t = 32767;
      if (t < -32768) t = -32768;
      vm = t;
      if (t >= th) begin sp = 1; nv = 0; ncnt = rf; end
      else         begin sp = 0; nv = t; ncnt = 0;  end
    end
  endfunction

  typedef struct { int sp; int vm; } res_t;
  res_t obs[$];   // results transferred out of the main instance
  res_t sobs[$];  // results transferred out of the saturation instance

  // model state
  int m_v = 0, m_cnt = 0, m_sp = 0, m_vm = 0;
  bit m_valid = 0;
  int s_v = 0, s_cnt = 0, s_sp = 0, s_vm = 0;
  bit s_valid = 0;

  // Compare at negedge, then advance the model to what the next posedge does.
  always @(negedge clk) begin
    bit rdy;
    int nv, nc, sp, vm;
    if (!nrst) begin
      m_v = 0; m_cnt = 0; m_valid = 0; m_sp = 0; m_vm = 0;
      s_v = 0; s_cnt = 0; s_valid = 0; s_sp = 0; s_vm = 0;
    end
    rdy = !clear && (!m_valid || out_ready);
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("in_ready",  int'(in_ready),  int'(rdy));
    chk("refrac",    int'(refrac),    int'(m_cnt != 0));
    if (m_valid) begin
      chk("out_spike", int'(out_spike), m_sp);
      chk("out_vmem",  int'(out_vmem),  m_vm);
    end
    chk("s_out_valid", int'(s_out_valid), int'(s_valid));
    if (s_valid) begin
      chk("s_out_spike", int'(s_out_spike), s_sp);
      chk("s_out_vmem",  int'(s_out_vmem),  s_vm);
    end
    if (nrst && out_valid && out_ready) obs.push_back('{int'(out_spike), int'(out_vmem)});
    if (nrst && s_out_valid) sobs.push_back('{int'(s_out_spike), int'(s_out_vmem)});

    if (nrst) begin
      if (clear) begin
        m_v = 0; m_cnt = 0; m_valid = 0;
      end else if (in_valid && rdy) begin
        lif_step(m_v, m_cnt, int'(in_sum), 64, 4, 2, nv, nc, sp, vm);
        m_v = nv; m_cnt = nc; m_sp = sp; m_vm = vm; m_valid = 1;
      end else if (out_ready) m_valid = 0;

      if (s_in_valid) begin
        lif_step(s_v, s_cnt, int'(s_in_sum), 32767, 0, 0, nv, nc, sp, vm);
        s_v = nv; s_cnt = nc; s_sp = sp; s_vm = vm; s_valid = 1;
      end else s_valid = 0;
    end
  end

  task automatic drive(input bit v, input int s, input bit r, input bit c);
    @(posedge clk); #1;
    in_valid = v; in_sum = 8'(s); out_ready = r; clear = c;
  endtask

  task automatic settle();
    drive(0, 0, 1, 0);
    @(negedge clk); #1;
  endtask

  task automatic pop_chk(input string nm, input int sp, input int vm);
    res_t r;
    if (obs.size() == 0) begin
      n_total++;
      $display("FAIL %s: no result, expected (%0d,%0d)", nm, sp, vm);
    end else begin
      r = obs.pop_front();
      chk({nm, "_spike"}, r.sp, sp);
      chk({nm, "_vmem"},  r.vm, vm);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_vmem",  int'(out_vmem), 0);
    chk("reset_spike", int'(out_spike), 0);
    nrst = 1;

    // integrate then fire, then refractory
    obs.delete();
    drive(1, 40, 1, 0);
    drive(1, 30, 1, 0);
    settle();
    pop_chk("int0", 0, 40);
    pop_chk("int1", 1, 68);
    chk("refrac_after_fire", int'(refrac), 1);
    drive(1, 100, 1, 0);
    drive(1, 100, 1, 0);
    drive(1, 10, 1, 0);
    settle();
    pop_chk("ref0", 0, 0);
    pop_chk("ref1", 0, 0);
    pop_chk("ref2", 0, 10);

    // leak with negative input
    drive(0, 0, 1, 1);
    drive(1, 40, 1, 0);
    drive(1, -128, 1, 0);
    drive(1, 0, 1, 0);
    settle();
    pop_chk("leak0", 0, 40);
    pop_chk("leak1", 0, -90);
    pop_chk("leak2", 0, -84);

    // backpressure: 3 stalled cycles, nothing lost or duplicated
    drive(0, 0, 1, 1);
    drive(1, 5, 0, 0);
    drive(1, 6, 0, 0);
    chk("bp_in_ready", int'(in_ready), 0);
    drive(1, 6, 0, 0);
    drive(1, 6, 0, 0);
    chk("bp_vmem_held", int'(out_vmem), 5);
    drive(1, 6, 1, 0);
    drive(1, 7, 1, 0);
    settle();
    pop_chk("bp0", 0, 5);
    pop_chk("bp1", 0, 11);
    pop_chk("bp2", 0, 18);
    chk("bp_count", obs.size(), 0);

    // reset mid-stream drops the in-flight result
    drive(1, 33, 1, 0);
    @(posedge clk); #1;
    in_valid = 0; nrst = 0;
    #2 chk("rst_valid", int'(out_valid), 0);
    drive(0, 0, 1, 0);
    nrst = 1;
    drive(1, 20, 1, 0);
    settle();
    pop_chk("rst0", 0, 20);
    chk("rst_count", obs.size(), 0);

    // clear with a simultaneous input: input not consumed, membrane zeroed
    drive(1, 50, 1, 1);
    drive(1, 20, 1, 0);
    settle();
    pop_chk("clr0", 0, 20);
    chk("clr_count", obs.size(), 0);

    // saturation on the no-leak instance
    sobs.delete();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1; s_in_valid = 1; s_in_sum = 8'sd127;
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1; s_in_valid = 1; s_in_sum = -8'sd128;
    end
    @(posedge clk); #1; s_in_valid = 0;
    @(negedge clk); #1;
    chk("sat_count", sobs.size(), 600);
    if (sobs.size() == 600) begin
      chk("sat_257_vmem",  sobs[257].vm, 32766);
      chk("sat_258_spike", sobs[258].sp, 1);
      chk("sat_258_vmem",  sobs[258].vm, 32767);
      chk("sat_259_vmem",  sobs[259].vm, 127);
      chk("sat_neg_vmem",  sobs[599].vm, -32768);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sum    = 8'($urandom_range(0, 110) - 45);
      clear     = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 199) == 0) begin
        nrst = 0;
        @(posedge clk); #1;
        nrst = 1;
      end
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
